// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor (a - b - borrow_in),
//               LSB first, one bit per clock, valid/ready on both sides.
//               Define SERIAL_SUB_OVERFLOW_EN to add the o_overflow port.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             o_overflow
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_a0;
    logic             w_b0;
    logic             w_diff_bit;
    logic             w_borrow_next;
    logic             w_last;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Single full-subtractor cell
    assign w_a0          = sa_q[0];
    assign w_b0          = sb_q[0];
    assign w_diff_bit    = w_a0 ^ w_b0 ^ br_q;
    assign w_borrow_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & br_q);
    assign w_last        = (cnt_q == C_LAST_CNT);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid) state_d = S_SHIFT;
            S_SHIFT: if (w_last)  state_d = S_DONE;
            S_DONE:  if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; operands are only sampled in IDLE
    always_comb begin
        sa_d  = sa_q;
        sb_d  = sb_q;
        res_d = res_q;
        br_d  = br_q;
        cnt_d = cnt_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    sa_d  = i_a;
                    sb_d  = i_b;
                    br_d  = i_borrow;
                    cnt_d = '0;
                    res_d = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = i_a[WIDTH-1];
                    b_msb_d = i_b[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                res_d = {w_diff_bit, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = w_borrow_next;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_SUB_OVERFLOW_EN
                // The bit produced on the last cycle is the result MSB
                if (w_last) begin
                    ovf_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ w_diff_bit);
                end
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sa_q  <= '0;
            sb_q  <= '0;
            res_q <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            res_q <= res_d;
            br_q  <= br_d;
            cnt_q <= cnt_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Outputs decode flops only; the result is masked so a partial value never leaks
    always_comb begin
        o_ready  = (state_q == S_IDLE);
        o_valid  = (state_q == S_DONE);
        o_diff   = (state_q == S_DONE) ? res_q : '0;
        o_borrow = (state_q == S_DONE) & br_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        o_overflow = (state_q == S_DONE) & ovf_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor (WIDTH=8); overflow
//               checks are active when SERIAL_SUB_OVERFLOW_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_borrow;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             o_overflow;
`endif

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_borrow  (i_borrow),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_diff    (o_diff),
        .o_borrow  (o_borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .o_overflow(o_overflow)
`endif
    );

    // Reference model: WIDTH+1-bit subtraction, sign bit is the borrow-out
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        exp_t         e;
        logic [WIDTH:0] full;
        full     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        e.diff   = full[WIDTH-1:0];
        e.borrow = full[WIDTH];
        e.ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ full[WIDTH-1]);
        return e;
    endfunction

    // Present one operand pair; returns #1 after the accept edge
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        int n;
        n = 0;
        @(negedge clk);
        while (o_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout: o_ready=%b required 1", o_ready);
        end
        i_valid  = 1'b1;
        i_a      = a;
        i_b      = b;
        i_borrow = bin;
        sb_q.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Count edges from the accept edge until o_valid rises (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (o_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (o_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: o_valid=%b required 1 after %0d cycles", o_valid, n);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_ready, o_valid, o_diff, o_borrow} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b diff=%h borrow=%b required 1 0 00 0",
                     o_ready, o_valid, o_diff, o_borrow);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %b required 0", o_overflow);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int   n;
        exp_t e;
        send(8'h35, 8'h12, 1'b0);
        wait_valid(n);
        checks++;
        if (n !== WIDTH) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required %0d", n, WIDTH);
        end
        e = sb_q.pop_front();
        checks++;
        if (o_diff !== e.diff || o_borrow !== e.borrow || e.diff !== 8'h23) begin
            errors++;
            $display("FAIL basic_35_12: diff=%h borrow=%b required %h %b", o_diff, o_borrow, e.diff, e.borrow);
        end
        release_result();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: valid=%b ready=%b required 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] av [2] = '{8'h00, 8'h10};
        logic [WIDTH-1:0] bv [2] = '{8'h01, 8'h0F};
        logic             cv [2] = '{1'b0, 1'b1};
        logic [WIDTH-1:0] dv [2] = '{8'hFF, 8'h00};
        logic             rv [2] = '{1'b1, 1'b0};
        int               n;
        exp_t             e;
        for (int i = 0; i < 2; i++) begin
            send(av[i], bv[i], cv[i]);
            wait_valid(n);
            e = sb_q.pop_front();
            checks++;
            if (o_diff !== dv[i] || o_borrow !== rv[i] || o_diff !== e.diff || o_borrow !== e.borrow) begin
                errors++;
                $display("FAIL wrap_%0d: diff=%h borrow=%b required %h %b", i, o_diff, o_borrow, dv[i], rv[i]);
            end
            release_result();
        end
    endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
    task automatic test_overflow();
        logic [WIDTH-1:0] av [2] = '{8'h80, 8'h05};
        logic [WIDTH-1:0] bv [2] = '{8'h01, 8'h03};
        logic [WIDTH-1:0] dv [2] = '{8'h7F, 8'h02};
        logic             ov [2] = '{1'b1, 1'b0};
        int               n;
        exp_t             e;
        for (int i = 0; i < 2; i++) begin
            send(av[i], bv[i], 1'b0);
            wait_valid(n);
            e = sb_q.pop_front();
            checks++;
            if (o_diff !== dv[i] || o_overflow !== ov[i] || o_overflow !== e.ovf) begin
                errors++;
                $display("FAIL overflow_%0d: diff=%h ovf=%b required %h %b", i, o_diff, o_overflow, dv[i], ov[i]);
            end
            release_result();
        end
    endtask
`endif

    task automatic test_stall();
        int   n;
        exp_t e;
        send(8'h5A, 8'hC3, 1'b1);
        wait_valid(n);
        e = sb_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            i_valid = i[0];
            checks++;
            if (o_valid !== 1'b1 || o_diff !== e.diff || o_borrow !== e.borrow || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle_%0d: valid=%b ready=%b diff=%h borrow=%b required 1 0 %h %b",
                         i, o_valid, o_ready, o_diff, o_borrow, e.diff, e.borrow);
            end
        end
        i_valid = 1'b0;
        release_result();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b required 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_ignore_inputs();
        int   n;
        exp_t e;
        send(8'hA7, 8'h3C, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) begin
            @(negedge clk);
            i_valid  = ~i_valid;
            i_a      = WIDTH'($urandom);
            i_b      = WIDTH'($urandom);
            i_borrow = ~i_borrow;
            checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignore_shift_%0d: ready=%b valid=%b required 0 0", i, o_ready, o_valid);
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_valid(n);
        e = sb_q.pop_front();
        checks++;
        if (o_diff !== e.diff || o_borrow !== e.borrow) begin
            errors++;
            $display("FAIL ignore_result: diff=%h borrow=%b required %h %b", o_diff, o_borrow, e.diff, e.borrow);
        end
        release_result();
        repeat (3) @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_second_op: ready=%b valid=%b required 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_random();
        int   n;
        exp_t e;
        for (int k = 0; k < 500; k++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            wait_valid(n);
            e = sb_q.pop_front();
            checks++;
            if (o_diff !== e.diff || o_borrow !== e.borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
                || o_overflow !== e.ovf
`endif
               ) begin
                errors++;
                $display("FAIL random_%0d: diff=%h borrow=%b required %h %b", k, o_diff, o_borrow, e.diff, e.borrow);
            end
            release_result();
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        exp_t e;
        send(8'h35, 8'h12, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_valid, o_diff, o_borrow} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_outputs: ready=%b valid=%b diff=%h borrow=%b required 1 0 00 0",
                     o_ready, o_valid, o_diff, o_borrow);
        end
        sb_q.delete(0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h35, 8'h12, 1'b0);
        wait_valid(n);
        e = sb_q.pop_front();
        checks++;
        if (n !== WIDTH || o_diff !== 8'h23 || o_borrow !== e.borrow) begin
            errors++;
            $display("FAIL reset_mid_rerun: cycles=%0d diff=%h borrow=%b required %0d 23 %b",
                     n, o_diff, o_borrow, WIDTH, e.borrow);
        end
        release_result();
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_a      = '0;
        i_b      = '0;
        i_borrow = 1'b0;
        i_ready  = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
`ifdef SERIAL_SUB_OVERFLOW_EN
        test_overflow();
`endif
        test_stall();
        test_ignore_inputs();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
